neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter N_INPUTS, default 4: number of input/weight pairs per evaluation, legal range 1..16.
REQ-002 Parameter BASE_ADDR, default 0: weight ROM address of the first weight; BASE_ADDR+N_INPUTS SHALL be <=128.
REQ-003 Parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before saturation, legal range 0..12.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle request to begin an evaluation; sampled only in IDLE.
REQ-007 in_valid  input  1  in_data holds a valid activation.
REQ-008 in_data  input  8  unsigned activation.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 rom_address  output  8  weight ROM address.
REQ-011 rom_enable  output  1  weight ROM enable; the ROM drives rom_data combinationally while high.
REQ-012 rom_data  input  8  unsigned weight from ROM; high-Z when rom_enable is low.
REQ-013 out_data  output  8  saturated neuron result.
REQ-014 out_valid  output  1  out_data is valid.
REQ-015 out_ready  input  1  consumer accepts out_data.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, RUN and OUT.
REQ-018 IDLE: start=1 -> accumulator cleared to 0, index cleared to 0, next state RUN; otherwise stay in IDLE.
REQ-019 RUN: rom_enable=1, rom_address=BASE_ADDR+index (8-bit), in_ready=1.
REQ-020 RUN, in_valid=1: accumulator += in_data*rom_data (16-bit unsigned product, 20-bit unsigned accumulator), index increments.
REQ-021 RUN, in_valid=0: accumulator and index hold; rom_address stays stable.
REQ-022 RUN: the transfer with index==N_INPUTS-1 SHALL move the FSM to OUT on the same edge that performs the final accumulation.
REQ-023 OUT: out_valid=1, out_data=min(accumulator>>SHIFT, 255), in_ready=0, rom_enable=0.
REQ-024 OUT: out_ready=1 -> next state IDLE; out_ready=0 -> out_data and out_valid hold unchanged.
REQ-025 Outside RUN: rom_enable=0 and in_ready=0; rom_data SHALL be ignored there (it is high-Z).
REQ-026 start in RUN or OUT is ignored, with no effect on the accumulator or index.
REQ-027 Latency from start to out_valid SHALL be N_INPUTS+1 cycles when in_valid is held high continuously.
REQ-028 out_data is registered or derived only from registered state; no combinational path from in_data or rom_data to out_data.
REQ-029 Accumulator SHALL NOT wrap for legal parameters (16*255*255 < 2^20).

Reset
REQ-030 rst_n low -> FSM=IDLE, accumulator=0, index=0, out_valid=0, out_data=0, in_ready=0, rom_enable=0, rom_address=BASE_ADDR, busy=0, immediately and without a clock edge.
REQ-031 Reset asserted mid-RUN or mid-OUT SHALL abandon the evaluation; the first cycle after release is IDLE with no out_valid.

Verification
REQ-032 ROM weights 10,10,11,11; start; in_data 1,2,3,4 with in_valid held high -> rom_address 0,1,2,3; out_valid 5 cycles after start; out_data=107.
REQ-033 Same ROM; in_data=255 on all four transfers -> accumulator=10710, out_data=255 (saturated); with SHIFT=6 -> out_data=167.
REQ-034 in_valid low for 3 cycles between the 2nd and 3rd transfers -> rom_address holds at 2 during the gap; out_data=107; latency extends by 3 cycles.
REQ-035 out_ready held low for 4 cycles in OUT -> out_valid and out_data=107 stable for all 4 cycles; IDLE on the cycle after out_ready=1; start pulses during RUN/OUT ignored.
REQ-036 rst_n pulsed low after the 2nd transfer -> all outputs at reset values asynchronously; next start with inputs 1,1,1,1 -> out_data=42.

Source files
------------

// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate engine.
// Streams N_INPUTS unsigned activations and multiplies each one by a weight
// read from an external combinational ROM. The 20-bit sum is shifted right
// by SHIFT and saturated to 8 bits. The result is held on out_data with a
// valid/ready handshake until the consumer accepts it.
//
// Parameter ranges: N_INPUTS 1..16, SHIFT 0..12, and BASE_ADDR+N_INPUTS <= 128.
// Within these ranges the accumulator cannot wrap, because 16*255*255 < 2^20.
module neuron_mac #(
    parameter int N_INPUTS  = 4,
    parameter int BASE_ADDR = 0,
    parameter int SHIFT     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] rom_address,
    output logic       rom_enable,
    input  logic [7:0] rom_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    // State encoding is kept as plain constants so the state register stays
    // a simple 2-bit vector for downstream tools.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic [4:0] LAST_INDEX = 5'(N_INPUTS - 1);
    localparam logic [7:0] BASE       = 8'(BASE_ADDR);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [19:0] acc;
    logic [19:0] acc_next;
    logic [4:0]  index;
    logic [4:0]  index_next;
    logic [15:0] product;
    logic [19:0] shifted;
    logic        transfer;

    // An activation is consumed only in RUN. Outside RUN, rom_data is high-Z
    // and never reaches the accumulator.
    assign transfer = (state == RUN) && in_valid;

    // The operands are zero-extended before the multiply so the full 16-bit
    // unsigned product is kept.
    assign product = {8'h00, in_data} * {8'h00, rom_data};

    // Next-state, accumulator and index update.
    always_comb begin
        // NOTE: every variable gets a default first; a path that left one
        // unassigned would infer a latch.
        state_next = state;
        acc_next   = acc;
        index_next = index;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = 20'd0;
                    index_next = 5'd0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // A start pulse here is ignored. With in_valid low, the
                // accumulator, the index and the address all hold.
                if (transfer) begin
                    acc_next   = acc + {4'h0, product};
                    index_next = index + 5'd1;
                    // The final accumulation and the move to OUT happen on
                    // the same edge.
                    if (index == LAST_INDEX) begin
                        state_next = OUT;
                    end
                end
            end
            OUT: begin
                // The result is held until the consumer takes it.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers. Reset abandons any evaluation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= 20'd0;
            index <= 5'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that
            // every register samples the values from before the edge.
            state <= state_next;
            acc   <= acc_next;
            index <= index_next;
        end
    end

    // Handshake and ROM-side outputs decode directly from registered state.
    assign in_ready    = (state == RUN);
    assign rom_enable  = (state == RUN);
    assign busy        = (state != IDLE);
    assign out_valid   = (state == OUT);
    assign rom_address = BASE + {3'b000, index};

    // The result comes only from the registered accumulator, so there is no
    // path from in_data or rom_data to out_data. In reset the accumulator is
    // zero, which makes out_data zero as well.
    assign shifted  = acc >> SHIFT;
    assign out_data = (shifted > 20'd255) ? 8'hFF : shifted[7:0];

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac.
// Two instances run in lockstep on the same stimulus: one with SHIFT=0 and
// one with SHIFT=6. Each instance has its own copy of the weight ROM model.
`timescale 1ns/1ps
module tb_neuron_mac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready_a,   in_ready_b;
    logic [7:0] rom_address_a, rom_address_b;
    logic       rom_enable_a, rom_enable_b;
    wire  [7:0] rom_data_a,   rom_data_b;
    logic [7:0] out_data_a,   out_data_b;
    logic       out_valid_a,  out_valid_b;
    logic       busy_a,       busy_b;

    logic [7:0] rom [128];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational ROM that drives high-Z while disabled.
    assign rom_data_a = rom_enable_a ? rom[rom_address_a[6:0]] : 8'bz;
    assign rom_data_b = rom_enable_b ? rom[rom_address_b[6:0]] : 8'bz;

    neuron_mac #(.N_INPUTS(4), .BASE_ADDR(0), .SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready_a), .rom_address(rom_address_a),
        .rom_enable(rom_enable_a), .rom_data(rom_data_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a)
    );

    neuron_mac #(.N_INPUTS(4), .BASE_ADDR(0), .SHIFT(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready_b), .rom_address(rom_address_b),
        .rom_enable(rom_enable_b), .rom_data(rom_data_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one evaluation: pulse start, then make four transfers with an
    // optional in_valid gap before the third one. With start_in_run set, a
    // start pulse is also driven during the gap/run cycles. The task waits,
    // with a bound, for out_valid and returns the number of cycles counted
    // from the start cycle.
    task automatic do_eval(input logic [7:0] vals [4], input int gap_len,
                           input logic start_in_run, output int lat);
        start = 1'b1;
        lat   = 0;
        step();
        lat++;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    start    = start_in_run;
                    check("gap_addr", 32'(rom_address_a), 32'd2);
                    step();
                    lat++;
                end
            end
            in_valid = 1'b1;
            in_data  = vals[i];
            start    = start_in_run;
            check("run_addr", 32'(rom_address_a), 32'(i));
            step();
            lat++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        while (!out_valid_a && lat < 50) begin
            step();
            lat++;
        end
        check("out_valid_seen", 32'(out_valid_a), 32'd1);
    endtask

    // Accept the result and confirm the block returns to IDLE.
    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_out_valid", 32'(out_valid_a), 32'd0);
    endtask

    initial begin
        logic [7:0] v [4];
        int lat;

        for (int i = 0; i < 128; i++) rom[i] = 8'd0;
        rom[0] = 8'd10; rom[1] = 8'd10; rom[2] = 8'd11; rom[3] = 8'd11;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        #22;
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data", 32'(out_data_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_rom_enable", 32'(rom_enable_a), 32'd0);
        check("rst_rom_address", 32'(rom_address_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic evaluation: inputs 1,2,3,4 give 107, and 107>>6 = 1.
        v = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_eval(v, 0, 1'b0, lat);
        check("basic_latency", 32'(lat), 32'd5);
        check("basic_out_data", 32'(out_data_a), 32'd107);
        check("basic_out_shift6", 32'(out_data_b), 32'd1);
        check("out_in_ready", 32'(in_ready_a), 32'd0);
        check("out_rom_enable", 32'(rom_enable_a), 32'd0);
        check("out_busy", 32'(busy_a), 32'd1);
        accept();

        // Saturation: 255*42 = 10710 saturates to 255, and 10710>>6 = 167.
        v = '{8'd255, 8'd255, 8'd255, 8'd255};
        do_eval(v, 0, 1'b0, lat);
        check("sat_latency", 32'(lat), 32'd5);
        check("sat_out_data", 32'(out_data_a), 32'd255);
        check("sat_shift6", 32'(out_data_b), 32'd167);
        accept();

        // A 3-cycle in_valid gap before the third transfer adds 3 cycles.
        v = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_eval(v, 3, 1'b0, lat);
        check("gap_latency", 32'(lat), 32'd8);
        check("gap_out_data", 32'(out_data_a), 32'd107);
        accept();

        // Backpressure in OUT, with start pulses during RUN and OUT ignored.
        do_eval(v, 1, 1'b1, lat);
        check("bp_latency", 32'(lat), 32'd6);
        for (int k = 0; k < 4; k++) begin
            start = 1'b1;
            check("bp_out_valid", 32'(out_valid_a), 32'd1);
            check("bp_out_data", 32'(out_data_a), 32'd107);
            step();
        end
        start = 1'b0;
        check("bp_still_valid", 32'(out_valid_a), 32'd1);
        accept();

        // Reset asserted after the second transfer abandons the evaluation.
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'd1;
        step();
        in_data = 8'd2;
        step();
        check("pre_rst_addr", 32'(rom_address_a), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy_a), 32'd0);
        check("async_in_ready", 32'(in_ready_a), 32'd0);
        check("async_rom_enable", 32'(rom_enable_a), 32'd0);
        check("async_rom_address", 32'(rom_address_a), 32'd0);
        check("async_out_valid", 32'(out_valid_a), 32'd0);
        check("async_out_data", 32'(out_data_a), 32'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy_a), 32'd0);
        check("post_rst_out_valid", 32'(out_valid_a), 32'd0);
        v = '{8'd1, 8'd1, 8'd1, 8'd1};
        do_eval(v, 0, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd5);
        check("post_rst_out_data", 32'(out_data_a), 32'd42);
        accept();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
